vec_dot_accum: RTL
==================

Name: vec_dot_accum

Overview:
- Receiving end of the 4x8x8 packed-multiplier output stream (out_valid/product).
- Consumes one 64-bit product word per valid beat and splits it into four unsigned 16-bit lane products.
- Reduces the four lanes and accumulates across a programmed vector length.
- Presents the finished int8 dot-product result through a valid/ready handshake to downstream logic.

Parameters:
- ACC_W, 32, accumulator and result width in bits (>=18).
- CNT_W, 8, width of vector-length field and beat counter.

Ports:
- clk  in  1  system clock, all logic on posedge
- rst_n  in  1  synchronous active-low reset, sampled on posedge clk
- start  in  1  one-cycle pulse; begins a new accumulation (honoured in IDLE only)
- vec_len  in  CNT_W  number of product words to accumulate; sampled with start
- prod_valid  in  1  product word valid; connect to multiplier out_valid
- prod_data  in  64  packed products; lane k = prod_data[16k+15:16k], unsigned
- res_valid  out  1  result available
- res_ready  in  1  downstream accepts result
- res_data  out  ACC_W  accumulated dot product
- busy  out  1  high in ACC or DONE
- overflow  out  1  sticky; set when a sum exceeded 2^ACC_W-1 during current job
- stray_err  out  1  sticky; prod_valid seen outside ACC

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE; acc, count, res_data = 0; res_valid, busy, overflow, stray_err = 0.
- No backpressure on the product side. In ACC, every prod_valid beat is accepted.
- Lane sum: 18-bit unsigned sum of the four lanes, computed combinationally. It is zero-extended and added to acc in the same cycle.
- IDLE:
  - start=1 and vec_len!=0: latch vec_len, clear acc, count, overflow; go to ACC.
  - start=1 and vec_len==0: acc=0; go to DONE directly, so res_valid=1 on the next cycle with res_data=0.
- ACC:
  - On prod_valid: acc += lane sum; count += 1.
  - When the accepted beat makes count==vec_len: go to DONE. res_valid rises the cycle after the last beat (latency 1).
  - start in ACC is ignored.
- DONE:
  - res_valid=1; res_data=acc, held stable until res_ready.
  - Handshake (res_valid & res_ready): go to IDLE next cycle; res_valid falls.
  - start in DONE, including the handshake cycle, is ignored. A new job can start on the cycle after return to IDLE.
- prod_valid in IDLE or DONE: word dropped; acc untouched; stray_err set. stray_err clears only on reset.
- overflow: set whenever acc + lane sum carries out of ACC_W bits. Cleared at the next accepted start.
- busy = (state != IDLE).
- Reset asserted mid-ACC or mid-DONE: next cycle is IDLE with all outputs at reset values. The partial result is discarded.

Optional Feature:
- Macro: VEC_DOT_ACC_SAT_EN.
- Defined: on carry-out, acc clamps to 2^ACC_W-1 and stays there for the rest of the job; overflow is also set.
- Not defined: acc wraps modulo 2^ACC_W; overflow still set.

Test Plan:
- Single word: start, vec_len=1, one beat 0xFE01FE01FE01FE01 -> res_valid one cycle after the beat, res_data=0x3F804 (4*65025), overflow=0.
- Two words: vec_len=2, beats 0x097E148416820F78 then 0x0C300C2C32EE7E7B with 3 idle cycles between them -> res_data=0x10DC1; busy high from cycle after start until cycle after handshake.
- Zero length and backpressure: start with vec_len=0 -> res_valid next cycle, res_data=0. Hold res_ready=0 for 5 cycles -> res_valid and res_data stable; assert res_ready -> IDLE next cycle. A start during DONE is ignored.
- Overflow, ACC_W=20: vec_len=17, all beats 0xFE01FE01FE01FE01.
  - With VEC_DOT_ACC_SAT_EN: res_data=0xFFFFF, overflow=1.
  - Without: res_data=0x37844, overflow=1.
- Stray beat: prod_valid with 0x0001000100010001 while IDLE -> stray_err=1. A following vec_len=1 job with the same word -> res_data=4.
- Reset mid-job: vec_len=4, after 2 beats pull rst_n low for 1 cycle -> next cycle busy=0, res_valid=0, overflow=0, stray_err=0. A fresh vec_len=1 job with 0x000000000000FE01 -> res_data=0xFE01.

Source files
------------

// File: rtl/vec_dot_accum.sv
// vec_dot_accum: receives the 4-lane packed multiplier product stream and
// reduces each 64-bit word to one 18-bit lane sum. It accumulates those sums
// over a programmed vector length and offers the result on a valid/ready port.
// Optional build macro: VEC_DOT_ACC_SAT_EN. When it is defined, the
// accumulator saturates on carry-out. When it is not defined, the
// accumulator wraps.
module vec_dot_accum #(
  parameter int ACC_W = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] vec_len,
  input  logic             prod_valid,
  input  logic [63:0]      prod_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data,
  output logic             busy,
  output logic             overflow,
  output logic             stray_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] len_q;
  logic             ovf_q;
  logic             stray_q;

  logic [17:0]      lane_sum;
  logic [ACC_W:0]   sum_ext;
  logic             carry;
  logic [ACC_W-1:0] acc_next;
  logic [CNT_W-1:0] count_inc;

  // Reduce the four unsigned 16-bit lanes and form the next accumulator value
  always_comb begin
    lane_sum = 18'(prod_data[15:0])  + 18'(prod_data[31:16]) +
               18'(prod_data[47:32]) + 18'(prod_data[63:48]);
    sum_ext  = {1'b0, acc} + {{(ACC_W-17){1'b0}}, lane_sum};
    carry    = sum_ext[ACC_W];
`ifdef VEC_DOT_ACC_SAT_EN
    acc_next = carry ? '1 : sum_ext[ACC_W-1:0];
`else
    acc_next = sum_ext[ACC_W-1:0];
`endif
    count_inc = count + CNT_W'(1);
  end

  // Control FSM, accumulator and sticky status flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      acc     <= '0;
      count   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
      stray_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (prod_valid) stray_q <= 1'b1;
          if (start) begin
            acc   <= '0;
            count <= '0;
            ovf_q <= 1'b0;
            len_q <= vec_len;
            state <= (vec_len == '0) ? S_DONE : S_ACC;
          end
        end
        S_ACC: begin
          if (prod_valid) begin
            acc   <= acc_next;
            count <= count_inc;
            if (carry) ovf_q <= 1'b1;
            if (count_inc == len_q) state <= S_DONE;
          end
        end
        S_DONE: begin
          if (prod_valid) stray_q <= 1'b1;
          if (res_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from registered state; acc holds steady while in DONE
  always_comb begin
    res_valid = (state == S_DONE);
    busy      = (state != S_IDLE);
    res_data  = acc;
    overflow  = ovf_q;
    stray_err = stray_q;
  end

endmodule
